// File: rtl/btn_pkg.sv
// Shared state type and default timing constants for the push-button event decoder.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } btn_state_t;

  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;
  localparam int CNT_W_DEF     = 12;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level/tick inputs and classified event outputs of the decoder.
// master = surrounding logic (drives level and tick), slave = the decoder.
interface button_event_decoder_if;

  logic tick;
  logic level;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic toggle;
  logic held;

  modport master (
    output tick,
    output level,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  toggle,
    input  held
  );

  modport slave (
    input  tick,
    input  level,
    output short_press,
    output long_press,
    output repeat_pulse,
    output toggle,
    output held
  );

endinterface

// File: rtl/ms_counter.sv
// Tick counter with clear, tick enable and an equality hit against a runtime limit.
// A hit clears the count on the same edge, so the next period starts from zero.
module ms_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_reg;

  assign hit = en & tick & (cnt_reg == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || hit) begin
      cnt_reg <= '0;
    end else if (en && tick) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies presses of one debounced button into SHORT/LONG/REPEAT strobes plus a toggle level.
// Define BTN_REPEAT_EN to generate REPEAT strobes while held after a long press.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  bus
);

`ifdef BTN_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
  localparam int CNT_MAX   = max2(LONG_MS, REPEAT_MS);
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_MS - 1);
`else
  localparam bit REPEAT_ON = 1'b0;
  localparam int CNT_MAX   = LONG_MS;
`endif
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_MS - 1);

  if (LONG_MS < 2 || LONG_MS > 4095) begin : g_bad_long
    $error("LONG_MS outside 2..4095");
  end
  if (REPEAT_MS < 1 || REPEAT_MS > 4095) begin : g_bad_repeat
    $error("REPEAT_MS outside 1..4095");
  end
  if (CNT_MAX >= (1 << CNT_W)) begin : g_bad_width
    $error("CNT_W too narrow for the configured limits");
  end

  btn_state_t       state_reg, state_next;
  logic             in_q_reg, prev_q_reg;
  logic             press;
  logic             short_reg, short_next;
  logic             long_reg, long_next;
  logic             repeat_reg, repeat_next;
  logic             toggle_reg, toggle_next;
  logic             held_reg, held_next;
  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] cnt_limit;

  // Input pipeline resets high so a button held through reset never looks like a fresh press.
  assign press = in_q_reg & ~prev_q_reg;

  // Counting only happens while the button is still seen pressed, so a release always wins.
  assign cnt_clr = (state_reg == IDLE);
  assign cnt_en  = in_q_reg & ((state_reg == PRESS) | (REPEAT_ON & (state_reg == HOLD)));

`ifdef BTN_REPEAT_EN
  assign cnt_limit = (state_reg == HOLD) ? REP_LIM : LONG_LIM;
`else
  assign cnt_limit = LONG_LIM;
`endif

  ms_counter #(
    .CNT_W (CNT_W)
  ) u_ms_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tick  (bus.tick),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      in_q_reg   <= 1'b1;
      prev_q_reg <= 1'b1;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      toggle_reg <= 1'b0;
      held_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_q_reg   <= bus.level;
      prev_q_reg <= in_q_reg;
      short_reg  <= short_next;
      long_reg   <= long_next;
      repeat_reg <= repeat_next;
      toggle_reg <= toggle_next;
      held_reg   <= held_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (press) state_next = PRESS;
      PRESS: begin
        if (!in_q_reg)    state_next = IDLE;
        else if (cnt_hit) state_next = HOLD;
      end
      HOLD:    if (!in_q_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    toggle_next = toggle_reg;
    held_next   = (state_next != IDLE);
    case (state_reg)
      PRESS: begin
        if (!in_q_reg) begin
          short_next  = 1'b1;
          toggle_next = ~toggle_reg;
        end else if (cnt_hit) begin
          long_next = 1'b1;
        end
      end
      HOLD:    repeat_next = REPEAT_ON & in_q_reg & cnt_hit;
      default: ;
    endcase
  end

  assign bus.short_press  = short_reg;
  assign bus.long_press   = long_reg;
  assign bus.repeat_pulse = repeat_reg;
  assign bus.toggle       = toggle_reg;
  assign bus.held         = held_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: directed scenarios plus random presses against a duration-based reference model.
`timescale 1ns/1ps
module tb_button_event_decoder;

  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int CNT_W     = 12;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  button_event_decoder_if bus();

  button_event_decoder #(
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int phase = 0;

  // Reference model: a press is accepted two edges after the level rises, counts
  // the ticks it survives, and is classified by that count when it ends.
  bit m_in_q, m_prev, m_active;
  int m_ticks;
  bit e_short, e_long, e_rep, e_toggle, e_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_q = 1'b1; m_prev = 1'b1; m_active = 1'b0; m_ticks = 0;
      e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_toggle = 1'b0; e_held = 1'b0;
    end else begin
      e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      if (!m_active) begin
        if (m_in_q && !m_prev) begin
          m_active = 1'b1;
          m_ticks  = 0;
        end
      end else if (!m_in_q) begin
        m_active = 1'b0;
        if (m_ticks < LONG_MS) begin
          e_short  = 1'b1;
          e_toggle = !e_toggle;
        end
      end else if (bus.tick) begin
        m_ticks++;
        if (m_ticks == LONG_MS) e_long = 1'b1;
        else if (REP_EN && m_ticks > LONG_MS && ((m_ticks - LONG_MS) % REPEAT_MS) == 0) e_rep = 1'b1;
      end
      e_held = m_active;
      m_prev = m_in_q;
      m_in_q = bus.level;
    end
  end

  int mon_short = 0, mon_long = 0, mon_rep = 0, mon_held = 0;
  int exp_short = 0, exp_long = 0, exp_rep = 0;
  int mon_mism = 0, mon_overlap = 0;

  always @(negedge clk) begin
    if ({bus.short_press, bus.long_press, bus.repeat_pulse, bus.toggle, bus.held} !==
        {e_short, e_long, e_rep, e_toggle, e_held}) begin
      mon_mism++;
      if (mon_mism <= 5)
        $display("note t=%0t dut s/l/r/t/h=%b%b%b%b%b model=%b%b%b%b%b", $time,
                 bus.short_press, bus.long_press, bus.repeat_pulse, bus.toggle, bus.held,
                 e_short, e_long, e_rep, e_toggle, e_held);
    end
    if (bus.short_press === 1'b1) mon_short++;
    if (bus.long_press === 1'b1) mon_long++;
    if (bus.repeat_pulse === 1'b1) mon_rep++;
    if (bus.held === 1'b1) mon_held++;
    if (int'(bus.short_press) + int'(bus.long_press) + int'(bus.repeat_pulse) > 1) mon_overlap++;
    exp_short += int'(e_short);
    exp_long  += int'(e_long);
    exp_rep   += int'(e_rep);
  end

  int b_short, b_long, b_rep, b_held, b_mism;

  task automatic snap();
    b_short = mon_short; b_long = mon_long; b_rep = mon_rep;
    b_held = mon_held; b_mism = mon_mism;
  endtask

  // One clock per call; TICK is high for one cycle in every ten.
  task automatic step(input bit lvl);
    @(posedge clk);
    #1;
    bus.level = lvl;
    bus.tick  = (phase == 9);
    phase     = (phase + 1) % 10;
  endtask

  task automatic align();
    while (phase != 0) step(bus.level);
  endtask

  task automatic hold(input bit lvl, input int cycles);
    repeat (cycles) step(lvl);
  endtask

  task automatic pulse_reset(input bit lvl);
    step(lvl);
    rst_n = 1'b0;
    hold(lvl, 3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 4);
    n_checks++; if (bus.short_press !== 1'b0) begin n_errors++; $display("FAIL reset_short got %b want 0", bus.short_press); end
    n_checks++; if (bus.long_press !== 1'b0) begin n_errors++; $display("FAIL reset_long got %b want 0", bus.long_press); end
    n_checks++; if (bus.repeat_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_repeat got %b want 0", bus.repeat_pulse); end
    n_checks++; if (bus.toggle !== 1'b0) begin n_errors++; $display("FAIL reset_toggle got %b want 0", bus.toggle); end
    n_checks++; if (bus.held !== 1'b0) begin n_errors++; $display("FAIL reset_held got %b want 0", bus.held); end
    $display("txn reset: outputs s/l/r/t/h=%b%b%b%b%b", bus.short_press, bus.long_press,
             bus.repeat_pulse, bus.toggle, bus.held);
  endtask

  task automatic test_short_press();
    align(); snap();
    hold(1'b1, 30);
    hold(1'b0, 20);
    n_checks++; if (mon_short - b_short !== 1) begin n_errors++; $display("FAIL short_count got %0d want 1", mon_short - b_short); end
    n_checks++; if (mon_long - b_long !== 0) begin n_errors++; $display("FAIL short_no_long got %0d want 0", mon_long - b_long); end
    n_checks++; if (bus.toggle !== 1'b1) begin n_errors++; $display("FAIL short_toggle got %b want 1", bus.toggle); end
    n_checks++; if (mon_held - b_held !== 30) begin n_errors++; $display("FAIL short_held_cycles got %0d want 30", mon_held - b_held); end
    n_checks++; if (mon_mism - b_mism !== 0) begin n_errors++; $display("FAIL short_model got %0d diverging cycles want 0", mon_mism - b_mism); end
    $display("txn short press 3 ticks: short=%0d long=%0d toggle=%b", mon_short - b_short, mon_long - b_long, bus.toggle);
  endtask

  task automatic test_long_press();
    align(); snap();
    hold(1'b1, 100);
    hold(1'b0, 20);
    n_checks++; if (mon_long - b_long !== 1) begin n_errors++; $display("FAIL long_count got %0d want 1", mon_long - b_long); end
    n_checks++; if (mon_rep - b_rep !== (REP_EN ? 2 : 0)) begin n_errors++; $display("FAIL long_repeats got %0d want %0d", mon_rep - b_rep, REP_EN ? 2 : 0); end
    n_checks++; if (mon_short - b_short !== 0) begin n_errors++; $display("FAIL long_no_short got %0d want 0", mon_short - b_short); end
    n_checks++; if (bus.toggle !== 1'b1) begin n_errors++; $display("FAIL long_toggle got %b want 1", bus.toggle); end
    n_checks++; if (mon_mism - b_mism !== 0) begin n_errors++; $display("FAIL long_model got %0d diverging cycles want 0", mon_mism - b_mism); end
    $display("txn long press 10 ticks: long=%0d repeat=%0d short=%0d", mon_long - b_long, mon_rep - b_rep, mon_short - b_short);
  endtask

  task automatic test_release_on_tick();
    // Level drops one cycle before the 5th counted tick, so release and threshold coincide.
    align(); snap();
    hold(1'b1, 48);
    hold(1'b0, 20);
    n_checks++; if (mon_short - b_short !== 1) begin n_errors++; $display("FAIL coincide_short got %0d want 1", mon_short - b_short); end
    n_checks++; if (mon_long - b_long !== 0) begin n_errors++; $display("FAIL coincide_long got %0d want 0", mon_long - b_long); end
    n_checks++; if (mon_mism - b_mism !== 0) begin n_errors++; $display("FAIL coincide_model got %0d diverging cycles want 0", mon_mism - b_mism); end
    $display("txn release on 5th tick: short=%0d long=%0d", mon_short - b_short, mon_long - b_long);
  endtask

  task automatic test_held_through_reset();
    pulse_reset(1'b1);
    snap();
    hold(1'b1, 200);
    n_checks++; if (mon_short + mon_long + mon_rep - b_short - b_long - b_rep !== 0) begin n_errors++; $display("FAIL stuck_strobes got %0d want 0", mon_short + mon_long + mon_rep - b_short - b_long - b_rep); end
    n_checks++; if (mon_held - b_held !== 0) begin n_errors++; $display("FAIL stuck_held got %0d cycles want 0", mon_held - b_held); end
    hold(1'b0, 5);
    align(); snap();
    hold(1'b1, 20);
    hold(1'b0, 20);
    n_checks++; if (mon_short - b_short !== 1) begin n_errors++; $display("FAIL repress_short got %0d want 1", mon_short - b_short); end
    n_checks++; if (bus.toggle !== 1'b1) begin n_errors++; $display("FAIL repress_toggle got %b want 1", bus.toggle); end
    $display("txn held through reset then re-press: short=%0d toggle=%b", mon_short - b_short, bus.toggle);
  endtask

  task automatic test_reset_mid_press();
    hold(1'b0, 5);
    align();
    hold(1'b1, 32);
    n_checks++; if (bus.held !== 1'b1) begin n_errors++; $display("FAIL midreset_pre_held got %b want 1", bus.held); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.short_press, bus.long_press, bus.repeat_pulse, bus.toggle, bus.held} !== 5'b0) begin
      n_errors++; $display("FAIL midreset_outputs got %b want 00000",
                           {bus.short_press, bus.long_press, bus.repeat_pulse, bus.toggle, bus.held}); end
    hold(1'b1, 3);
    rst_n = 1'b1;
    snap();
    hold(1'b1, 20);
    hold(1'b0, 20);
    n_checks++; if (mon_short + mon_long + mon_rep - b_short - b_long - b_rep !== 0) begin n_errors++; $display("FAIL midreset_strobes got %0d want 0", mon_short + mon_long + mon_rep - b_short - b_long - b_rep); end
    n_checks++; if (mon_held - b_held !== 0) begin n_errors++; $display("FAIL midreset_held got %0d cycles want 0", mon_held - b_held); end
    $display("txn reset mid-press: strobes after=%0d", mon_short + mon_long + mon_rep - b_short - b_long - b_rep);
  endtask

  task automatic test_two_short();
    pulse_reset(1'b0);
    align(); snap();
    hold(1'b1, 20);
    hold(1'b0, 15);
    n_checks++; if (bus.toggle !== 1'b1) begin n_errors++; $display("FAIL two_short_mid_toggle got %b want 1", bus.toggle); end
    hold(1'b1, 20);
    hold(1'b0, 15);
    n_checks++; if (bus.toggle !== 1'b0) begin n_errors++; $display("FAIL two_short_end_toggle got %b want 0", bus.toggle); end
    n_checks++; if (mon_short - b_short !== 2) begin n_errors++; $display("FAIL two_short_count got %0d want 2", mon_short - b_short); end
    $display("txn two short presses: short=%0d toggle=%b", mon_short - b_short, bus.toggle);
  endtask

  task automatic test_random();
    int on_len, off_len;
    for (int i = 0; i < 16; i++) begin
      snap();
      on_len  = $urandom_range(1, 130);
      off_len = $urandom_range(1, 40);
      hold(1'b1, on_len);
      hold(1'b0, off_len);
      $display("txn random %0d: on=%0d off=%0d short=%0d long=%0d repeat=%0d", i, on_len, off_len,
               mon_short - b_short, mon_long - b_long, mon_rep - b_rep);
    end
    hold(1'b0, 10);
    n_checks++; if (mon_mism !== 0) begin n_errors++; $display("FAIL model_total got %0d diverging cycles want 0", mon_mism); end
    n_checks++; if (mon_short !== exp_short) begin n_errors++; $display("FAIL total_short got %0d want %0d", mon_short, exp_short); end
    n_checks++; if (mon_long !== exp_long) begin n_errors++; $display("FAIL total_long got %0d want %0d", mon_long, exp_long); end
    n_checks++; if (mon_rep !== exp_rep) begin n_errors++; $display("FAIL total_repeat got %0d want %0d", mon_rep, exp_rep); end
    n_checks++; if (mon_overlap !== 0) begin n_errors++; $display("FAIL strobe_overlap got %0d want 0", mon_overlap); end
  endtask

  initial begin
    bus.level = 1'b0;
    bus.tick  = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_release_on_tick();
    test_held_through_reset();
    test_reset_mid_press();
    test_two_short();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
